// File: rtl/bike_led_ctrl_if.sv
// Button inputs and display outputs of the bicycle lighting controller.
// The controller takes the slave modport; the board or bench takes the master modport.
interface bike_led_ctrl_if;
  logic       _RST;
  logic       BTN7;
  logic       BTN3;
  logic       BTN5;
  logic       BTN6;
  logic [7:0] row;
  logic [7:0] R_col;
  logic [7:0] G_col;
  logic [7:0] DS;
  logic [7:0] duan;

  modport master (
    output _RST, BTN7, BTN3, BTN5, BTN6,
    input  row, R_col, G_col, DS, duan
  );

  modport slave (
    input  _RST, BTN7, BTN3, BTN5, BTN6,
    output row, R_col, G_col, DS, duan
  );
endinterface

// File: rtl/bike_led_ctrl.sv
// Bicycle lighting controller: 8x8 red/green arrow/brake matrix plus 4-digit status display.
// Optional macro DEBOUNCE_EN: BTN7 is accepted only after DEB_CYCLES stable-high clocks.
module bike_led_ctrl #(
  parameter int unsigned BLINK_HALF = 250,
  parameter int unsigned SEC_CYCLES = 500
`ifdef DEBOUNCE_EN
  ,
  parameter int unsigned DEB_CYCLES = 4
`endif
) (
  input logic            clk,
  input logic            rst,
  bike_led_ctrl_if.slave bus
);

  localparam int unsigned BlinkW = $clog2(BLINK_HALF + 1);
  localparam int unsigned TickW  = $clog2(SEC_CYCLES + 1);

  localparam logic [2:0] ModeOff    = 3'd0;
  localparam logic [2:0] ModeIdle   = 3'd1;
  localparam logic [2:0] ModeLeft   = 3'd2;
  localparam logic [2:0] ModeRight  = 3'd3;
  localparam logic [2:0] ModeHazard = 3'd4;
  localparam logic [2:0] ModeBrake  = 3'd5;

  logic              power_q;
  logic [2:0]        scan_q;
  logic [1:0]        dig_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_on_q;
  logic [TickW-1:0]  tick_q;
  logic [3:0]        ones_q;
  logic [3:0]        tens_q;
  logic [7:0]        row_q;
  logic [7:0]        r_col_q;
  logic [7:0]        g_col_q;
  logic [7:0]        ds_q;
  logic [7:0]        duan_q;

  logic              press;
  logic [2:0]        mode;
  logic              brake_turn;
  logic [7:0]        g_col_d;
  logic [7:0]        duan_d;
  logic [3:0]        ones_disp;
  logic [3:0]        tens_disp;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 8'h3F;
      4'h1:    seg7 = 8'h06;
      4'h2:    seg7 = 8'h5B;
      4'h3:    seg7 = 8'h4F;
      4'h4:    seg7 = 8'h66;
      4'h5:    seg7 = 8'h6D;
      4'h6:    seg7 = 8'h7D;
      4'h7:    seg7 = 8'h07;
      4'h8:    seg7 = 8'h7F;
      4'h9:    seg7 = 8'h6F;
      4'hA:    seg7 = 8'h77;
      4'hB:    seg7 = 8'h7C;
      4'hC:    seg7 = 8'h39;
      4'hD:    seg7 = 8'h5E;
      4'hE:    seg7 = 8'h79;
      default: seg7 = 8'h71;
    endcase
  endfunction

  function automatic logic [7:0] left_arrow(input logic [2:0] i);
    case (i)
      3'd0:    left_arrow = 8'h10;
      3'd1:    left_arrow = 8'h30;
      3'd2:    left_arrow = 8'h7F;
      3'd3:    left_arrow = 8'hFF;
      3'd4:    left_arrow = 8'hFF;
      3'd5:    left_arrow = 8'h7F;
      3'd6:    left_arrow = 8'h30;
      default: left_arrow = 8'h10;
    endcase
  endfunction

  function automatic logic [7:0] bit_rev(input logic [7:0] x);
    for (int k = 0; k < 8; k++) begin
      bit_rev[k] = x[7-k];
    end
  endfunction

`ifdef DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  logic [DebW-1:0] deb_cnt_q;
  logic            armed_q;

  // armed_q drops after a press so a held button yields exactly one toggle.
  assign press = bus.BTN7 && armed_q && (deb_cnt_q == DebW'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      armed_q   <= 1'b1;
    end else if (!bus.BTN7) begin
      deb_cnt_q <= '0;
      armed_q   <= 1'b1;
    end else if (armed_q) begin
      if (press) begin
        deb_cnt_q <= '0;
        armed_q   <= 1'b0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end
`else
  logic b7_q;

  assign press = bus.BTN7 && !b7_q;

  always_ff @(posedge clk) begin
    if (rst) b7_q <= 1'b0;
    else     b7_q <= bus.BTN7;
  end
`endif

  always_comb begin
    mode = ModeOff;
    if (power_q) begin
      if (bus.BTN3 && bus.BTN5) mode = ModeHazard;
      else if (bus.BTN3)        mode = ModeLeft;
      else if (bus.BTN5)        mode = ModeRight;
      else if (bus.BTN6)        mode = ModeBrake;
      else                      mode = ModeIdle;
    end
  end

  assign brake_turn = power_q && bus.BTN6 && (bus.BTN3 || bus.BTN5);

  always_comb begin
    g_col_d = 8'h00;
    if (power_q && blink_on_q) begin
      if (mode == ModeLeft || mode == ModeHazard)  g_col_d = g_col_d | left_arrow(scan_q);
      if (mode == ModeRight || mode == ModeHazard) g_col_d = g_col_d | bit_rev(left_arrow(scan_q));
    end
  end

  // The ride time is retained while off but displayed as 00.
  assign ones_disp = power_q ? ones_q : 4'd0;
  assign tens_disp = power_q ? tens_q : 4'd0;

  always_comb begin
    duan_d = 8'h00;
    case (dig_q)
      2'd0:    duan_d = seg7(ones_disp);
      2'd1:    duan_d = seg7(tens_disp);
      2'd2:    duan_d = 8'h00;
      default: duan_d = seg7({1'b0, mode}) | {brake_turn, 7'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      power_q     <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      tick_q      <= '0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
    end else begin
      if (press) power_q <= !power_q;
      if ((press && !power_q) || !bus._RST) begin
        blink_cnt_q <= '0;
        blink_on_q  <= 1'b1;
        tick_q      <= '0;
        ones_q      <= 4'd0;
        tens_q      <= 4'd0;
      end else if (power_q) begin
        if (blink_cnt_q == BlinkW'(BLINK_HALF - 1)) begin
          blink_cnt_q <= '0;
          blink_on_q  <= !blink_on_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
        if (tick_q == TickW'(SEC_CYCLES - 1)) begin
          tick_q <= '0;
          if (ones_q == 4'd9) begin
            ones_q <= 4'd0;
            tens_q <= (tens_q == 4'd9) ? 4'd0 : tens_q + 1'b1;
          end else begin
            ones_q <= ones_q + 1'b1;
          end
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q  <= 3'd0;
      dig_q   <= 2'd0;
      row_q   <= 8'hFF;
      r_col_q <= 8'h00;
      g_col_q <= 8'h00;
      ds_q    <= 8'hFF;
      duan_q  <= 8'h00;
    end else begin
      scan_q  <= scan_q + 1'b1;
      dig_q   <= dig_q + 1'b1;
      row_q   <= power_q ? ~(8'd1 << scan_q) : 8'hFF;
      r_col_q <= (power_q && bus.BTN6) ? 8'hFF : 8'h00;
      g_col_q <= g_col_d;
      ds_q    <= ~(8'd1 << dig_q);
      duan_q  <= duan_d;
    end
  end

  assign bus.row   = row_q;
  assign bus.R_col = r_col_q;
  assign bus.G_col = g_col_q;
  assign bus.DS    = ds_q;
  assign bus.duan  = duan_q;

endmodule

// File: tb/tb_bike_led_ctrl.sv
// Directed self-checking bench for bike_led_ctrl with hand-computed display patterns.
module tb_bike_led_ctrl;
  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int vectors = 0;
  int errors  = 0;

  bike_led_ctrl_if bus ();

  bike_led_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Returns X if the digit never appears, which then miscompares.
  task automatic read_digit(input int d, output logic [7:0] v);
    logic [7:0] want;
    want = ~(8'd1 << d);
    v = 8'hxx;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.DS == want) begin
        v = bus.duan;
        break;
      end
    end
  endtask

  task automatic read_row(input int r, output logic [7:0] rc, output logic [7:0] gc);
    logic [7:0] want;
    want = ~(8'd1 << r);
    rc = 8'hxx;
    gc = 8'hxx;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.row == want) begin
        rc = bus.R_col;
        gc = bus.G_col;
        break;
      end
    end
  endtask

  task automatic press_power(output int unsigned t0);
    @(negedge clk);
    t0 = cyc;
    bus.BTN7 = 1'b1;
    tick(5);
    bus.BTN7 = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int bad;
    logic [7:0] ds_seq [4];
    ds_seq[0] = 8'hFE; ds_seq[1] = 8'hFD; ds_seq[2] = 8'hFB; ds_seq[3] = 8'hF7;
    rst = 1'b1;
    bus._RST = 1'b1; bus.BTN7 = 1'b0; bus.BTN3 = 1'b0; bus.BTN5 = 1'b0; bus.BTN6 = 1'b0;
    tick(2);
    vectors++; if (bus.row !== 8'hFF) begin errors++; $display("FAIL rst_row: got %h want ff", bus.row); end
    vectors++; if (bus.R_col !== 8'h00) begin errors++; $display("FAIL rst_r: got %h want 00", bus.R_col); end
    vectors++; if (bus.G_col !== 8'h00) begin errors++; $display("FAIL rst_g: got %h want 00", bus.G_col); end
    vectors++; if (bus.DS !== 8'hFF) begin errors++; $display("FAIL rst_ds: got %h want ff", bus.DS); end
    vectors++; if (bus.duan !== 8'h00) begin errors++; $display("FAIL rst_duan: got %h want 00", bus.duan); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.DS !== ds_seq[k]) begin
        errors++; $display("FAIL ds_seq%0d: got %h want %h", k, bus.DS, ds_seq[k]);
      end
    end
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.row !== 8'hFF || bus.R_col !== 8'h00 || bus.G_col !== 8'h00) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL off_matrix: got %0d bad cycles want 0", bad); end
    read_digit(0, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL off_ones: got %h want 3f", v); end
    read_digit(1, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL off_tens: got %h want 3f", v); end
    read_digit(3, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL off_mode: got %h want 3f", v); end
  endtask

  task automatic test_power();
    int unsigned t0;
    logic [7:0] v, rc, gc;
    press_power(t0);
    wait_to(t0 + 20);
    read_digit(3, v);
    vectors++; if (v !== 8'h06) begin errors++; $display("FAIL pwr_mode: got %h want 06", v); end
    read_row(5, rc, gc);
    vectors++; if (rc !== 8'h00 || gc !== 8'h00) begin
      errors++; $display("FAIL idle_cols: got r=%h g=%h want 00/00", rc, gc);
    end
    wait_to(t0 + 250);
    read_digit(0, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL sec_ones0: got %h want 3f", v); end
    wait_to(t0 + 515);
    read_digit(0, v);
    vectors++; if (v !== 8'h06) begin errors++; $display("FAIL sec_ones1: got %h want 06", v); end
    wait_to(t0 + 1015);
    read_digit(0, v);
    vectors++; if (v !== 8'h5B) begin errors++; $display("FAIL sec_ones2: got %h want 5b", v); end
    read_digit(1, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL sec_tens0: got %h want 3f", v); end
    press_power(t0);
    tick(5);
    read_digit(3, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL pwr_off_mode: got %h want 3f", v); end
    read_digit(0, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL pwr_off_ones: got %h want 3f", v); end
    vectors++; if (bus.row !== 8'hFF) begin errors++; $display("FAIL pwr_off_row: got %h want ff", bus.row); end
  endtask

  task automatic test_left();
    int unsigned t0;
    int bad;
    logic [7:0] v, rc, gc;
    bus.BTN3 = 1'b1;
    press_power(t0);
    wait_to(t0 + 20);
    read_row(0, rc, gc);
    vectors++; if (gc !== 8'h10) begin errors++; $display("FAIL left_row0: got %h want 10", gc); end
    read_row(3, rc, gc);
    vectors++; if (gc !== 8'hFF) begin errors++; $display("FAIL left_row3: got %h want ff", gc); end
    vectors++; if (rc !== 8'h00) begin errors++; $display("FAIL left_red: got %h want 00", rc); end
    read_digit(3, v);
    vectors++; if (v !== 8'h5B) begin errors++; $display("FAIL left_mode: got %h want 5b", v); end
    wait_to(t0 + 265);
    bad = 0;
    while (cyc < t0 + 495) begin
      @(negedge clk);
      if (bus.G_col !== 8'h00) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL blink_off: got %0d lit cycles want 0", bad); end
    wait_to(t0 + 530);
    read_row(3, rc, gc);
    vectors++; if (gc !== 8'hFF) begin errors++; $display("FAIL blink_on2: got %h want ff", gc); end
    bus.BTN3 = 1'b0;
    press_power(t0);
  endtask

  task automatic test_right();
    int unsigned t0;
    logic [7:0] v, rc, gc;
    bus.BTN5 = 1'b1;
    press_power(t0);
    wait_to(t0 + 20);
    read_row(0, rc, gc);
    vectors++; if (gc !== 8'h08) begin errors++; $display("FAIL right_row0: got %h want 08", gc); end
    read_row(2, rc, gc);
    vectors++; if (gc !== 8'hFE) begin errors++; $display("FAIL right_row2: got %h want fe", gc); end
    read_digit(3, v);
    vectors++; if (v !== 8'h4F) begin errors++; $display("FAIL right_mode: got %h want 4f", v); end
    bus.BTN5 = 1'b0;
    press_power(t0);
  endtask

  task automatic test_hazard();
    int unsigned t0;
    int bad;
    logic [7:0] v, rc, gc;
    bus.BTN3 = 1'b1; bus.BTN5 = 1'b1;
    press_power(t0);
    wait_to(t0 + 20);
    read_row(3, rc, gc);
    vectors++; if (gc !== 8'hFF) begin errors++; $display("FAIL haz_row3: got %h want ff", gc); end
    read_row(0, rc, gc);
    vectors++; if (gc !== 8'h18) begin errors++; $display("FAIL haz_row0: got %h want 18", gc); end
    read_digit(3, v);
    vectors++; if (v !== 8'h66) begin errors++; $display("FAIL haz_mode: got %h want 66", v); end
    bus.BTN6 = 1'b1;
    bad = 0;
    for (int r = 0; r < 8; r++) begin
      read_row(r, rc, gc);
      if (rc !== 8'hFF) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL haz_red: got %0d unlit rows want 0", bad); end
    read_digit(3, v);
    vectors++; if (v !== 8'hE6) begin errors++; $display("FAIL haz_dp: got %h want e6", v); end
    read_digit(2, v);
    vectors++; if (v !== 8'h00) begin errors++; $display("FAIL blank_dig: got %h want 00", v); end
    bus.BTN3 = 1'b0; bus.BTN5 = 1'b0; bus.BTN6 = 1'b0;
    press_power(t0);
  endtask

  task automatic test_brake();
    int unsigned t0;
    logic [7:0] v, rc, gc;
    bus.BTN6 = 1'b1;
    press_power(t0);
    wait_to(t0 + 20);
    read_digit(3, v);
    vectors++; if (v !== 8'h6D) begin errors++; $display("FAIL brake_mode: got %h want 6d", v); end
    read_row(6, rc, gc);
    vectors++; if (rc !== 8'hFF || gc !== 8'h00) begin
      errors++; $display("FAIL brake_cols: got r=%h g=%h want ff/00", rc, gc);
    end
    bus.BTN6 = 1'b0;
    press_power(t0);
  endtask

  task automatic test_wrap();
    int unsigned t0;
    logic [7:0] v;
    press_power(t0);
    wait_to(t0 + 49700);
    read_digit(0, v);
    vectors++; if (v !== 8'h6F) begin errors++; $display("FAIL sec99_ones: got %h want 6f", v); end
    read_digit(1, v);
    vectors++; if (v !== 8'h6F) begin errors++; $display("FAIL sec99_tens: got %h want 6f", v); end
    wait_to(t0 + 50200);
    read_digit(0, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL wrap_ones: got %h want 3f", v); end
    read_digit(1, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL wrap_tens: got %h want 3f", v); end
    wait_to(t0 + 50700);
    read_digit(0, v);
    vectors++; if (v !== 8'h06) begin errors++; $display("FAIL pre_clr: got %h want 06", v); end
    wait_to(t0 + 50750);
    bus._RST = 1'b0;
    tick(1);
    bus._RST = 1'b1;
    tick(2);
    read_digit(0, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL clr_ones: got %h want 3f", v); end
    read_digit(3, v);
    vectors++; if (v !== 8'h06) begin errors++; $display("FAIL clr_power: got %h want 06", v); end
    wait_to(t0 + 51100);
    read_digit(0, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL clr_tick: got %h want 3f", v); end
    wait_to(t0 + 51300);
    read_digit(0, v);
    vectors++; if (v !== 8'h06) begin errors++; $display("FAIL clr_resume: got %h want 06", v); end
  endtask

  task automatic test_rst_on();
    logic [7:0] v, rc, gc;
    bus.BTN6 = 1'b1;
    tick(10);
    read_row(1, rc, gc);
    vectors++; if (rc !== 8'hFF) begin errors++; $display("FAIL pre_rst_red: got %h want ff", rc); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus.row !== 8'hFF) begin errors++; $display("FAIL rst_on_row: got %h want ff", bus.row); end
    vectors++; if (bus.R_col !== 8'h00) begin errors++; $display("FAIL rst_on_r: got %h want 00", bus.R_col); end
    vectors++; if (bus.DS !== 8'hFF) begin errors++; $display("FAIL rst_on_ds: got %h want ff", bus.DS); end
    vectors++; if (bus.duan !== 8'h00) begin errors++; $display("FAIL rst_on_duan: got %h want 00", bus.duan); end
    rst = 1'b0;
    tick(20);
    vectors++; if (bus.row !== 8'hFF || bus.R_col !== 8'h00) begin
      errors++; $display("FAIL rst_power_off: got row=%h r=%h want ff/00", bus.row, bus.R_col);
    end
    read_digit(3, v);
    vectors++; if (v !== 8'h3F) begin errors++; $display("FAIL rst_on_mode: got %h want 3f", v); end
    bus.BTN6 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power();
    test_left();
    test_right();
    test_hazard();
    test_brake();
    test_wrap();
    test_rst_on();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
